// File: rtl/gpio_pio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pio_arbiter
// Description : Round-robin arbiter letting NUM_REQ local requesters share a
//               single zero-wait-state Avalon-MM PIO slave. Each grant runs
//               one single-beat read or write (IDLE -> ACCESS -> DONE) and
//               returns a one-cycle ack plus read data to the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_pio_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      m_chipselect,
  output logic                      m_write_n,
  output logic [ADDR_W-1:0]         m_address,
  output logic [31:0]               m_writedata,
  input  logic [31:0]               m_readdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]         state;
  logic [IDX_W-1:0]   last;       // index granted most recently
  logic [IDX_W-1:0]   gnt_idx;    // index of the running transaction
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic               win_found;
  logic [NUM_REQ-1:0] win_onehot;

  // Only the low DATA_W bits of the slave read data are returned.
  logic unused_readdata;
  assign unused_readdata = &{1'b0, m_readdata};

  // Rotating-priority search: first set request after 'last', wrapping.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = last;
    cand       = last;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_onehot = '0;
    win_onehot[win_idx] = 1'b1;
  end

  // Transaction sequencer: grant and latch command, one access cycle, ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      last         <= IDX_W'(NUM_REQ - 1);
      gnt_idx      <= '0;
      gnt          <= '0;
      ack          <= '0;
      rdata        <= '0;
      busy         <= 1'b0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= '0;
      m_writedata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            state        <= S_ACCESS;
            gnt          <= win_onehot;
            gnt_idx      <= win_idx;
            busy         <= 1'b1;
            m_chipselect <= 1'b1;
            m_write_n    <= ~req_write[win_idx];
            m_address    <= req_address[int'(win_idx)*ADDR_W +: ADDR_W];
            m_writedata  <= 32'(req_writedata[int'(win_idx)*DATA_W +: DATA_W]);
          end
        end
        S_ACCESS: begin
          // m_write_n still carries the latched command type here.
          if (m_write_n) begin
            rdata <= m_readdata[DATA_W-1:0];
          end
          m_chipselect <= 1'b0;
          m_write_n    <= 1'b1;
          ack          <= gnt;
          state        <= S_DONE;
        end
        S_DONE: begin
          last  <= gnt_idx;
          gnt   <= '0;
          ack   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          gnt          <= '0;
          ack          <= '0;
          busy         <= 1'b0;
          m_chipselect <= 1'b0;
          m_write_n    <= 1'b1;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
